// File: rtl/rcv_pkg.sv
// rtl/rcv_pkg.sv - shared constants, state type and header check for the receive deframer
package rcv_pkg;

    localparam int LEN_W_DEF    = 12;
    localparam int MAX_LEN_DEF  = 2047;
    localparam int CTRL_W       = 24;
    localparam int LEN_HI_MSB   = 23;
    localparam int LEN_HI_LSB   = 12;
    localparam int LEN_LO_MSB   = 11;
    localparam int LEN_LO_LSB   = 0;
    localparam int HDR_NIBBLES  = 6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR     = 2'd1,
        PAYLOAD = 2'd2,
        DROP    = 2'd3
    } rcv_state_e;

    // Both length copies must agree and the length must be in 1..max_len.
    function automatic logic hdr_ok(input logic [CTRL_W-1:0] ctrl, input int max_len);
        logic [LEN_HI_MSB-LEN_HI_LSB:0] len_hi;
        logic [LEN_LO_MSB-LEN_LO_LSB:0] len_lo;
        len_hi = ctrl[LEN_HI_MSB:LEN_HI_LSB];
        len_lo = ctrl[LEN_LO_MSB:LEN_LO_LSB];
        return (len_hi == len_lo) && (len_hi != '0) && (int'(len_hi) <= max_len);
    endfunction

endpackage

// File: rtl/rcv_nibble_packer.sv
// rtl/rcv_nibble_packer.sv - pairs PHY nibbles (low first) into bytes with a completion strobe
module rcv_nibble_packer (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [3:0] nibble_i,
    input  logic       dv_i,
    output logic [7:0] byte_o,
    output logic       byte_done_o,
    output logic       phase_o
);

    logic       phase_q;
    logic [3:0] low_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            phase_q <= 1'b0;
            low_q   <= 4'h0;
        end else if (!dv_i) begin
            phase_q <= 1'b0;
        end else begin
            phase_q <= ~phase_q;
            if (!phase_q) begin
                low_q <= nibble_i;
            end
        end
    end

    // The byte completes on the edge that samples its high nibble.
    assign byte_o      = {nibble_i, low_q};
    assign byte_done_o = dv_i & phase_q;
    assign phase_o     = phase_q;

endmodule

// File: rtl/rcv_phy_deframer.sv
// rtl/rcv_phy_deframer.sv - PHY nibble deframer: header check, payload extraction, length and drop accounting
module rcv_phy_deframer
    import rcv_pkg::*;
#(
    parameter int LEN_W   = LEN_W_DEF,
    parameter int MAX_LEN = MAX_LEN_DEF
) (
    input  logic               clk_phy,
    input  logic               reset,
    input  logic [3:0]         phy_data_in,
    input  logic               phy_rx_dv,
    output logic [7:0]         r_data_out,
    output logic               r_data_valid,
    output logic               r_frame_valid,
    output logic [CTRL_W-1:0]  r_ctrl_out,
    output logic               r_frame_end,
    output logic               r_len_err,
    output logic               r_hdr_err,
    output logic [7:0]         r_drop_cnt
);

    localparam logic [2:0] HDR_LAST = 3'(HDR_NIBBLES - 1);

    rcv_state_e        state_q, state_d;
    logic [CTRL_W-1:0] hdr_q, hdr_d;
    logic [2:0]        nib_q, nib_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              over_q, over_d;
    logic [7:0]        drop_q, drop_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [7:0]        data_q, data_d;
    logic              dvld_q, dvld_d;
    logic              fv_q, fv_d;
    logic              fe_q, fe_d;
    logic              le_q, le_d;
    logic              he_q, he_d;

    logic [7:0]        pk_byte;
    logic              pk_done;
    logic              pk_phase;
    logic [CTRL_W-1:0] ctrl_next;
    logic [LEN_W-1:0]  frame_len;
    logic              reject;

    rcv_nibble_packer u_packer (
        .clk_i       (clk_phy),
        .reset_i     (reset),
        .nibble_i    (phy_data_in),
        .dv_i        (phy_rx_dv),
        .byte_o      (pk_byte),
        .byte_done_o (pk_done),
        .phase_o     (pk_phase)
    );

    assign ctrl_next = {hdr_q[CTRL_W-9:0], pk_byte};
    assign frame_len = LEN_W'(hdr_q[LEN_HI_MSB:LEN_HI_LSB]);

    always_comb begin
        state_d = state_q;
        hdr_d   = hdr_q;
        nib_d   = nib_q;
        cnt_d   = cnt_q;
        over_d  = over_q;
        drop_d  = drop_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        dvld_d  = 1'b0;
        fv_d    = 1'b0;
        fe_d    = 1'b0;
        le_d    = 1'b0;
        he_d    = 1'b0;
        reject  = 1'b0;

        case (state_q)
            IDLE: begin
                if (phy_rx_dv) begin
                    state_d = HDR;
                    nib_d   = 3'd1;
                end
            end
            HDR: begin
                if (!phy_rx_dv) begin
                    reject  = 1'b1;
                    state_d = IDLE;
                end else begin
                    nib_d = nib_q + 3'd1;
                    if (pk_done) begin
                        hdr_d = ctrl_next;
                    end
                    if (nib_q == HDR_LAST) begin
                        if (hdr_ok(ctrl_next, MAX_LEN)) begin
                            state_d = PAYLOAD;
                            cnt_d   = '0;
                            over_d  = 1'b0;
                        end else begin
                            reject  = 1'b1;
                            state_d = DROP;
                        end
                    end
                end
            end
            PAYLOAD: begin
                if (!phy_rx_dv) begin
                    fe_d    = 1'b1;
                    le_d    = (cnt_q != frame_len) | over_q | pk_phase;
                    state_d = IDLE;
                end else if (pk_done) begin
                    // Bytes past the declared length are swallowed and only flagged.
                    if (cnt_q != frame_len) begin
                        data_d = pk_byte;
                        dvld_d = 1'b1;
                        cnt_d  = cnt_q + LEN_W'(1);
                        if (cnt_q == '0) begin
                            fv_d   = 1'b1;
                            ctrl_d = hdr_q;
                        end
                    end else begin
                        over_d = 1'b1;
                    end
                end
            end
            DROP: begin
                if (!phy_rx_dv) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (reject) begin
            he_d   = 1'b1;
            drop_d = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk_phy) begin
        if (reset) begin
            state_q <= IDLE;
            hdr_q   <= '0;
            nib_q   <= 3'd0;
            cnt_q   <= '0;
            over_q  <= 1'b0;
            drop_q  <= 8'd0;
            ctrl_q  <= '0;
            data_q  <= 8'd0;
            dvld_q  <= 1'b0;
            fv_q    <= 1'b0;
            fe_q    <= 1'b0;
            le_q    <= 1'b0;
            he_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            hdr_q   <= hdr_d;
            nib_q   <= nib_d;
            cnt_q   <= cnt_d;
            over_q  <= over_d;
            drop_q  <= drop_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
            dvld_q  <= dvld_d;
            fv_q    <= fv_d;
            fe_q    <= fe_d;
            le_q    <= le_d;
            he_q    <= he_d;
        end
    end

    assign r_data_out    = data_q;
    assign r_data_valid  = dvld_q;
    assign r_frame_valid = fv_q;
    assign r_ctrl_out    = ctrl_q;
    assign r_frame_end   = fe_q;
    assign r_len_err     = le_q;
    assign r_hdr_err     = he_q;
    assign r_drop_cnt    = drop_q;

endmodule

// File: tb/tb_rcv_phy_deframer.sv
// tb/tb_rcv_phy_deframer.sv - randomized self-checking bench for rcv_phy_deframer
module tb_rcv_phy_deframer;

    localparam int MAXL = 2047;

    logic        clk_phy;
    logic        reset;
    logic [3:0]  phy_data_in;
    logic        phy_rx_dv;
    logic [7:0]  r_data_out;
    logic        r_data_valid;
    logic        r_frame_valid;
    logic [23:0] r_ctrl_out;
    logic        r_frame_end;
    logic        r_len_err;
    logic        r_hdr_err;
    logic [7:0]  r_drop_cnt;

    rcv_phy_deframer dut (
        .clk_phy       (clk_phy),
        .reset         (reset),
        .phy_data_in   (phy_data_in),
        .phy_rx_dv     (phy_rx_dv),
        .r_data_out    (r_data_out),
        .r_data_valid  (r_data_valid),
        .r_frame_valid (r_frame_valid),
        .r_ctrl_out    (r_ctrl_out),
        .r_frame_end   (r_frame_end),
        .r_len_err     (r_len_err),
        .r_hdr_err     (r_hdr_err),
        .r_drop_cnt    (r_drop_cnt)
    );

    initial begin
        clk_phy = 1'b0;
        forever #5 clk_phy = ~clk_phy;
    end

    int cyc = 0;
    always @(posedge clk_phy) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // Observed events, written only by the monitor.
    int          obs_dv_cyc[$];
    logic [7:0]  obs_dv_dat[$];
    int          obs_fv_cyc[$];
    logic [23:0] obs_fv_ctrl[$];
    int          obs_fe_cyc[$];
    logic        obs_fe_le[$];
    int          obs_he_cyc[$];
    int          obs_stray = 0;

    always @(negedge clk_phy) begin
        if (!reset) begin
            if (r_data_valid) begin
                obs_dv_cyc.push_back(cyc);
                obs_dv_dat.push_back(r_data_out);
            end
            if (r_frame_valid) begin
                obs_fv_cyc.push_back(cyc);
                obs_fv_ctrl.push_back(r_ctrl_out);
            end
            if (r_frame_end) begin
                obs_fe_cyc.push_back(cyc);
                obs_fe_le.push_back(r_len_err);
            end else if (r_len_err) begin
                obs_stray <= obs_stray + 1;
            end
            if (r_hdr_err) obs_he_cyc.push_back(cyc);
        end
    end

    // Expected events and reference state, written only by the stimulus.
    int          exp_dv_cyc[$];
    logic [7:0]  exp_dv_dat[$];
    int          exp_fv_cyc[$];
    logic [23:0] exp_fv_ctrl[$];
    int          exp_fe_cyc[$];
    logic        exp_fe_le[$];
    int          exp_he_cyc[$];
    logic [23:0] exp_ctrl = 24'h0;
    int          exp_drop = 0;
    int rd_dv = 0, rd_fv = 0, rd_fe = 0, rd_he = 0, stray_base = 0;

    logic [3:0] tx[$];

    task automatic push_byte(input logic [7:0] b);
        tx.push_back(b[3:0]);
        tx.push_back(b[7:4]);
    endtask

    task automatic push_hdr(input logic [23:0] c);
        push_byte(c[23:16]);
        push_byte(c[15:8]);
        push_byte(c[7:0]);
    endtask

    // Predicts the outcome of the frame in tx from the wire rules alone.
    task automatic model_frame(input int t0);
        int n, len, nb, em;
        logic [23:0] c;
        n = tx.size();
        if (n < 6) begin
            exp_he_cyc.push_back(t0 + n + 1);
            if (exp_drop < 255) exp_drop++;
            return;
        end
        c = {tx[1], tx[0], tx[3], tx[2], tx[5], tx[4]};
        len = int'(c[23:12]);
        if (c[23:12] != c[11:0] || len < 1 || len > MAXL) begin
            exp_he_cyc.push_back(t0 + 6);
            if (exp_drop < 255) exp_drop++;
            return;
        end
        nb = (n - 6) / 2;
        em = (nb < len) ? nb : len;
        for (int k = 0; k < em; k++) begin
            exp_dv_cyc.push_back(t0 + 8 + 2 * k);
            exp_dv_dat.push_back({tx[7 + 2 * k], tx[6 + 2 * k]});
        end
        if (em > 0) begin
            exp_fv_cyc.push_back(t0 + 8);
            exp_fv_ctrl.push_back(c);
            exp_ctrl = c;
        end
        exp_fe_cyc.push_back(t0 + n + 1);
        exp_fe_le.push_back((nb != len) || (n % 2 == 1));
    endtask

    task automatic send_frame(input int gap);
        int t0;
        t0 = cyc;
        model_frame(t0);
        for (int i = 0; i < tx.size(); i++) begin
            phy_rx_dv   = 1'b1;
            phy_data_in = tx[i];
            @(posedge clk_phy); #1;
        end
        phy_rx_dv   = 1'b0;
        phy_data_in = 4'($urandom);
        repeat (gap) begin
            @(posedge clk_phy); #1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_phy); #1;
        end
    endtask

    task automatic check_events(input string tag);
        int n, m;
        n = obs_dv_cyc.size() - rd_dv;
        checks++;
        if (n != exp_dv_cyc.size()) begin
            errors++;
            $display("FAIL %s byte_count got=%0d exp=%0d", tag, n, exp_dv_cyc.size());
        end
        m = (n < exp_dv_cyc.size()) ? n : exp_dv_cyc.size();
        for (int i = 0; i < m; i++) begin
            checks++;
            if (obs_dv_cyc[rd_dv + i] !== exp_dv_cyc[i] || obs_dv_dat[rd_dv + i] !== exp_dv_dat[i]) begin
                errors++;
                $display("FAIL %s byte%0d got=%02h@%0d exp=%02h@%0d", tag, i,
                         obs_dv_dat[rd_dv + i], obs_dv_cyc[rd_dv + i], exp_dv_dat[i], exp_dv_cyc[i]);
            end
        end
        n = obs_fv_cyc.size() - rd_fv;
        checks++;
        if (n != exp_fv_cyc.size()) begin
            errors++;
            $display("FAIL %s frame_valid_count got=%0d exp=%0d", tag, n, exp_fv_cyc.size());
        end
        m = (n < exp_fv_cyc.size()) ? n : exp_fv_cyc.size();
        for (int i = 0; i < m; i++) begin
            checks++;
            if (obs_fv_cyc[rd_fv + i] !== exp_fv_cyc[i] || obs_fv_ctrl[rd_fv + i] !== exp_fv_ctrl[i]) begin
                errors++;
                $display("FAIL %s frame_valid%0d ctrl got=%06h@%0d exp=%06h@%0d", tag, i,
                         obs_fv_ctrl[rd_fv + i], obs_fv_cyc[rd_fv + i], exp_fv_ctrl[i], exp_fv_cyc[i]);
            end
        end
        n = obs_fe_cyc.size() - rd_fe;
        checks++;
        if (n != exp_fe_cyc.size()) begin
            errors++;
            $display("FAIL %s frame_end_count got=%0d exp=%0d", tag, n, exp_fe_cyc.size());
        end
        m = (n < exp_fe_cyc.size()) ? n : exp_fe_cyc.size();
        for (int i = 0; i < m; i++) begin
            checks++;
            if (obs_fe_cyc[rd_fe + i] !== exp_fe_cyc[i] || obs_fe_le[rd_fe + i] !== exp_fe_le[i]) begin
                errors++;
                $display("FAIL %s frame_end%0d len_err got=%0b@%0d exp=%0b@%0d", tag, i,
                         obs_fe_le[rd_fe + i], obs_fe_cyc[rd_fe + i], exp_fe_le[i], exp_fe_cyc[i]);
            end
        end
        n = obs_he_cyc.size() - rd_he;
        checks++;
        if (n != exp_he_cyc.size()) begin
            errors++;
            $display("FAIL %s hdr_err_count got=%0d exp=%0d", tag, n, exp_he_cyc.size());
        end
        m = (n < exp_he_cyc.size()) ? n : exp_he_cyc.size();
        for (int i = 0; i < m; i++) begin
            checks++;
            if (obs_he_cyc[rd_he + i] !== exp_he_cyc[i]) begin
                errors++;
                $display("FAIL %s hdr_err%0d cycle got=%0d exp=%0d", tag, i, obs_he_cyc[rd_he + i], exp_he_cyc[i]);
            end
        end
        checks++;
        if (obs_stray != stray_base) begin
            errors++;
            $display("FAIL %s stray_len_err got=%0d exp=0", tag, obs_stray - stray_base);
        end
        checks++;
        if (r_drop_cnt !== 8'(exp_drop)) begin
            errors++;
            $display("FAIL %s drop_cnt got=%0d exp=%0d", tag, r_drop_cnt, exp_drop);
        end
        checks++;
        if (r_ctrl_out !== exp_ctrl) begin
            errors++;
            $display("FAIL %s ctrl_out got=%06h exp=%06h", tag, r_ctrl_out, exp_ctrl);
        end
        rd_dv = obs_dv_cyc.size(); rd_fv = obs_fv_cyc.size();
        rd_fe = obs_fe_cyc.size(); rd_he = obs_he_cyc.size();
        stray_base = obs_stray;
        exp_dv_cyc.delete(); exp_dv_dat.delete(); exp_fv_cyc.delete(); exp_fv_ctrl.delete();
        exp_fe_cyc.delete(); exp_fe_le.delete(); exp_he_cyc.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1; phy_rx_dv = 1'b0; phy_data_in = 4'h0;
        idle(3);
        checks++;
        if ({r_data_valid, r_frame_valid, r_frame_end, r_len_err, r_hdr_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_pulses got=%05b exp=00000",
                     {r_data_valid, r_frame_valid, r_frame_end, r_len_err, r_hdr_err});
        end
        checks++;
        if (r_ctrl_out !== 24'h0 || r_data_out !== 8'h0) begin
            errors++;
            $display("FAIL reset_data got=%06h/%02h exp=000000/00", r_ctrl_out, r_data_out);
        end
        checks++;
        if (r_drop_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_drop got=%0d exp=0", r_drop_cnt);
        end
        reset = 1'b0;
        idle(2);
    endtask

    task automatic test_big_frame();
        tx.delete();
        push_hdr(24'h200200);
        for (int i = 0; i < 512; i++) push_byte((i < 4 || i >= 508) ? 8'h00 : 8'hFF);
        send_frame(1);
        idle(3);
        check_events("big_frame");
    endtask

    task automatic test_back_to_back();
        tx.delete();
        push_hdr(24'h2001FF);
        for (int i = 0; i < 4; i++) push_byte(8'($urandom));
        send_frame(1);
        checks++;
        if (r_ctrl_out !== exp_ctrl) begin
            errors++;
            $display("FAIL reject_keeps_ctrl got=%06h exp=%06h", r_ctrl_out, exp_ctrl);
        end
        tx.delete();
        push_hdr(24'h005005);
        for (int i = 0; i < 5; i++) push_byte(8'($urandom));
        send_frame(1);
        tx.delete();
        push_hdr(24'h003003);
        for (int i = 0; i < 3; i++) push_byte(8'($urandom));
        send_frame(1);
        idle(3);
        check_events("back_to_back");
    endtask

    task automatic test_odd_nibble();
        tx.delete();
        push_hdr(24'h004004);
        for (int i = 0; i < 3; i++) push_byte(8'($urandom));
        tx.push_back(4'($urandom));
        send_frame(2);
        idle(3);
        check_events("odd_nibble");
    endtask

    task automatic test_overlong();
        tx.delete();
        push_hdr(24'h002002);
        for (int i = 0; i < 5; i++) push_byte(8'($urandom));
        send_frame(1);
        idle(3);
        check_events("overlong");
    endtask

    task automatic test_random();
        int kind, len, nb;
        logic [11:0] lh, ll;
        for (int f = 0; f < 30; f++) begin
            tx.delete();
            kind = $urandom_range(0, 9);
            len  = $urandom_range(1, 12);
            lh = 12'(len); ll = 12'(len);
            case (kind)
                0: ll = lh ^ 12'(1 << $urandom_range(0, 11));
                1: begin lh = 12'd0; ll = 12'd0; end
                2: begin lh = 12'($urandom_range(MAXL + 1, 4095)); ll = lh; end
                3: begin lh = 12'(MAXL); ll = lh; end
                default: ;
            endcase
            if (kind == 4) begin
                nb = $urandom_range(1, 5);
                for (int i = 0; i < nb; i++) tx.push_back(4'($urandom));
            end else begin
                push_hdr({lh, ll});
                nb = len + $urandom_range(0, 4) - 2;
                if (nb < 0) nb = 0;
                for (int i = 0; i < nb; i++) push_byte(8'($urandom));
                if ($urandom_range(0, 3) == 0) tx.push_back(4'($urandom));
            end
            send_frame($urandom_range(1, 3));
        end
        idle(3);
        check_events("random");
    endtask

    task automatic test_runts();
        for (int r = 0; r < 256; r++) begin
            tx.delete();
            for (int i = 0; i < 4; i++) tx.push_back(4'($urandom));
            send_frame(1);
        end
        idle(3);
        check_events("runts");
        checks++;
        if (r_drop_cnt !== 8'd255) begin
            errors++;
            $display("FAIL drop_saturate got=%0d exp=255", r_drop_cnt);
        end
    endtask

    task automatic test_reset_mid();
        tx.delete();
        push_hdr(24'h00A00A);
        for (int i = 0; i < 10; i++) push_byte(8'($urandom));
        for (int i = 0; i < 12; i++) begin
            phy_rx_dv = 1'b1; phy_data_in = tx[i];
            @(posedge clk_phy); #1;
        end
        reset = 1'b1;
        @(posedge clk_phy); #1;
        checks++;
        if ({r_data_valid, r_frame_valid, r_frame_end, r_len_err, r_hdr_err} !== 5'b0
            || r_ctrl_out !== 24'h0 || r_data_out !== 8'h0) begin
            errors++;
            $display("FAIL reset_mid_outputs got=%05b/%06h/%02h exp=0",
                     {r_data_valid, r_frame_valid, r_frame_end, r_len_err, r_hdr_err}, r_ctrl_out, r_data_out);
        end
        checks++;
        if (r_drop_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid_drop got=%0d exp=0", r_drop_cnt);
        end
        idle(1);
        reset = 1'b0; phy_rx_dv = 1'b0;
        exp_drop = 0; exp_ctrl = 24'h0;
        rd_dv = obs_dv_cyc.size(); rd_fv = obs_fv_cyc.size();
        rd_fe = obs_fe_cyc.size(); rd_he = obs_he_cyc.size();
        stray_base = obs_stray;
        idle(8);
        check_events("reset_mid");
        tx.delete();
        push_hdr(24'h002002);
        push_byte(8'h5A); push_byte(8'hC3);
        send_frame(1);
        idle(3);
        check_events("after_reset");
    endtask

    initial begin
        test_reset();
        test_big_frame();
        test_back_to_back();
        test_odd_nibble();
        test_overlong();
        test_random();
        test_runts();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rcv_phy_deframer.md
# rcv_phy_deframer

Receive-side deframer on the PHY nibble interface; the counterpart of the transmit path that serialises frames onto phy_data_out. Samples a 4-bit PHY stream qualified by phy_rx_dv, strips and checks a 3-byte control header, and emits payload bytes plus a 24-bit control block on the f_-style frame interface. Runs entirely in the clk_phy domain. Crossing into clk_sys happens in the downstream receive FIFO.

## Interface
- LEN_W, 12, width of each length field in the control block
- MAX_LEN, 2047, largest legal payload length in bytes
- clk_phy  in  1  PHY clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- phy_data_in  in  4  PHY receive nibble
- phy_rx_dv  in  1  nibble valid; frame = one contiguous high run
- r_data_out  out  8  payload byte
- r_data_valid  out  1  r_data_out valid (one-cycle pulse per byte)
- r_frame_valid  out  1  pulse coincident with first payload byte's r_data_valid
- r_ctrl_out  out  24  received control block; held from r_frame_valid until next accepted header
- r_frame_end  out  1  pulse one cycle after phy_rx_dv sampled low for an accepted frame
- r_len_err  out  1  pulse with r_frame_end when payload count ≠ header length or nibble count odd
- r_hdr_err  out  1  one-cycle pulse when a header is rejected
- r_drop_cnt  out  8  rejected-header count, saturates at 255

## Operation
- Wire format: byte = low nibble first. Bytes 0..2 = control block, MSB byte first: ctrl[23:16], ctrl[15:8], ctrl[7:0]. Payload follows.
- Control block: ctrl[23:12] = payload length L, ctrl[11:0] = copy of L. Example: 24'h200200 = 512-byte payload.
- Header accepted iff ctrl[23:12] == ctrl[11:0], 1 ≤ L ≤ MAX_LEN. Otherwise reject.
- States:
  - IDLE: phy_rx_dv high → HDR, nibble 0 captured.
  - HDR: collects 6 nibbles.
    - Valid header → PAYLOAD.
    - Invalid header → DROP.
    - phy_rx_dv low before 6 nibbles (runt) → reject, IDLE.
  - PAYLOAD: assembles bytes and counts them (LEN_W-bit counter).
    - Bytes beyond L are not emitted and flag a length error.
    - phy_rx_dv low → pulse r_frame_end; also pulse r_len_err if count ≠ L or a dangling odd nibble is present; then IDLE.
  - DROP: no outputs; phy_rx_dv low → IDLE.
- Reject: r_hdr_err pulse; r_drop_cnt +1 (saturating); r_ctrl_out unchanged.
- Dangling odd trailing nibble is discarded, never emitted.

## Timing
- Edge E0 = first edge sampling phy_rx_dv=1; nibble n sampled at En.
- Header valid/invalid decided at E5; r_hdr_err high in the cycle after E5.
- Payload byte k completes at E(7+2k). r_data_valid, r_data_out and (k=0) r_frame_valid are registered, high in the cycle after E(7+2k): one-cycle latency, one byte every 2 clocks.
- r_ctrl_out updates in the same cycle as r_frame_valid.
- phy_rx_dv first sampled low at edge Ed:
  - r_frame_end and r_len_err high in the cycle after Ed.
  - Runt: r_hdr_err high in the cycle after Ed.
- Minimum gap: 1 low cycle. A new frame may begin on the very next edge after Ed; its nibble 0 is captured while r_frame_end is high.
- Reset: all outputs 0, r_ctrl_out 24'h000000, r_drop_cnt 0, state IDLE, phase 0. Reset mid-frame discards the frame with no error pulse. If phy_rx_dv is still high after reset, the remaining nibbles are treated as a new frame.

## Structure
- Package rcv_pkg:
  - LEN_W and MAX_LEN defaults.
  - Control-field slice constants (LEN_HI = 23:12, LEN_LO = 11:0).
  - State enum {IDLE, HDR, PAYLOAD, DROP}.
  - Header nibble count (6).
- Sub-module rcv_nibble_packer: nibble phase toggle plus low/high assembly → byte + byte_done strobe. Clears phase on phy_rx_dv low or reset.
- Top: FSM, header register, length counter/compare, drop counter, output registers.

## Test plan
- Frame, ctrl 24'h200200, 512 bytes 00×4/FF×504/00×4 → 512 r_data_valid pulses 2 clocks apart. r_frame_valid with byte 0, r_ctrl_out=24'h200200, r_frame_end one cycle after rx_dv low, r_len_err=0.
- Header 24'h2001FF → r_hdr_err pulse cycle after E5, no r_data_valid, r_drop_cnt=1. Back-to-back good frame after 1-cycle gap → received intact.
- Header 24'h004004, 3 payload bytes + 1 extra nibble → 3 bytes out, r_len_err=1 with r_frame_end.
- Header 24'h002002, 5 payload bytes → only 2 bytes emitted, r_len_err=1.
- Runt (rx_dv high 4 nibbles) ×256 → r_drop_cnt saturates at 255. Reset asserted mid-payload → all outputs 0, r_drop_cnt=0, no r_frame_end.
